// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between the pipeline (priority) and a long-latency unit.
// Optional statistics counters are enabled with `define RF_WRITE_ARBITER_STATS_EN.
module rf_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
`ifdef RF_WRITE_ARBITER_STATS_EN
    ,
    parameter int unsigned CNT_W = 8
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_wen,
    input  logic [4:0]  p_wsel,
    input  logic [31:0] p_wdat,
    output logic        p_stall,
    input  logic        l_valid,
    input  logic [4:0]  l_wsel,
    input  logic [31:0] l_wdat,
    output logic        l_ready,
    output logic        rf_wen,
    output logic [4:0]  rf_wsel,
    output logic [31:0] rf_wdat
`ifdef RF_WRITE_ARBITER_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_drops,
    output logic [CNT_W-1:0] stat_forces,
    output logic [CNT_W-1:0] stat_writes
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state, state_next;
    logic [3:0]  wait_cnt, wait_cnt_next;
    logic [4:0]  buf_wsel;
    logic [31:0] buf_wdat;
    logic        buf_v;
    logic        accept;
    logic        waw_hit;
    logic        sel_wen;
    logic [4:0]  sel_wsel;
    logic [31:0] sel_wdat;
    logic        stall;

    assign buf_v   = (state != IDLE);
    assign l_ready = !buf_v && !rst;
    assign accept  = l_valid && l_ready;
    assign waw_hit = p_wen && (p_wsel == buf_wsel) && (p_wsel != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            buf_wsel <= 5'd0;
            buf_wdat <= 32'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (accept) begin
                buf_wsel <= l_wsel;
                buf_wdat <= l_wdat;
            end
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        sel_wen       = 1'b0;
        sel_wsel      = 5'd0;
        sel_wdat      = 32'd0;
        stall         = 1'b0;
        case (state)
            IDLE: begin
                if (p_wen) begin
                    sel_wen  = 1'b1;
                    sel_wsel = p_wsel;
                    sel_wdat = p_wdat;
                end
                if (accept) begin
                    state_next    = WAIT;
                    wait_cnt_next = 4'd0;
                end
            end
            WAIT: begin
                if (p_wen) begin
                    sel_wen  = 1'b1;
                    sel_wsel = p_wsel;
                    sel_wdat = p_wdat;
                    if (waw_hit) begin
                        state_next    = IDLE;
                        wait_cnt_next = 4'd0;
                    end else if (wait_cnt + 4'd1 == LIMIT) begin
                        state_next    = FORCE;
                        wait_cnt_next = 4'd0;
                    end else begin
                        wait_cnt_next = wait_cnt + 4'd1;
                    end
                end else begin
                    sel_wen       = 1'b1;
                    sel_wsel      = buf_wsel;
                    sel_wdat      = buf_wdat;
                    state_next    = IDLE;
                    wait_cnt_next = 4'd0;
                end
            end
            FORCE: begin
                // A forced register-0 entry needs no port cycle, so P is let through instead.
                if (buf_wsel != 5'd0) begin
                    sel_wen  = 1'b1;
                    sel_wsel = buf_wsel;
                    sel_wdat = buf_wdat;
                    stall    = 1'b1;
                end else if (p_wen) begin
                    sel_wen  = 1'b1;
                    sel_wsel = p_wsel;
                    sel_wdat = p_wdat;
                end
                state_next    = IDLE;
                wait_cnt_next = 4'd0;
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    assign rf_wen  = !rst && sel_wen && (sel_wsel != 5'd0);
    assign rf_wsel = rst ? 5'd0 : sel_wsel;
    assign rf_wdat = rst ? 32'd0 : sel_wdat;
    assign p_stall = !rst && stall;

`ifdef RF_WRITE_ARBITER_STATS_EN
    logic drop_evt;
    logic force_evt;

    assign drop_evt  = (state == WAIT) && waw_hit;
    assign force_evt = (state == FORCE);

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_drops  <= '0;
            stat_forces <= '0;
            stat_writes <= '0;
        end else begin
            if (drop_evt && (stat_drops != '1))
                stat_drops <= stat_drops + 1'b1;
            if (force_evt && (stat_forces != '1))
                stat_forces <= stat_forces + 1'b1;
            if (rf_wen && (stat_writes != '1))
                stat_writes <= stat_writes + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: per-cycle vectors with a scoreboard queue.
module tb_rf_write_arbiter;

    localparam int LIMIT = 4;
    localparam int CW    = 8;

    typedef struct {
        int          id;
        logic        rst;
        logic        pw;
        logic [4:0]  ps;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  ls;
        logic [31:0] ld;
        logic        eStall;
        logic        eRdy;
        logic        eWen;
        logic [4:0]  eSel;
        logic [31:0] eDat;
        logic        chkDat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        p_wen;
    logic [4:0]  p_wsel;
    logic [31:0] p_wdat;
    logic        p_stall;
    logic        l_valid;
    logic [4:0]  l_wsel;
    logic [31:0] l_wdat;
    logic        l_ready;
    logic        rf_wen;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
`ifdef RF_WRITE_ARBITER_STATS_EN
    logic [CW-1:0] stat_drops;
    logic [CW-1:0] stat_forces;
    logic [CW-1:0] stat_writes;
`endif

    int   nChecks   = 0;
    int   nFails    = 0;
    int   rowNum    = 0;
    int   expDrops  = 0;
    int   expForces = 0;
    int   expWrites = 0;
    vec_t expQ[$];
    vec_t table_q[$];
    vec_t curVec;

    rf_write_arbiter #(
        .STARVE_LIMIT(LIMIT)
`ifdef RF_WRITE_ARBITER_STATS_EN
        ,
        .CNT_W(CW)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .p_wen(p_wen),
        .p_wsel(p_wsel),
        .p_wdat(p_wdat),
        .p_stall(p_stall),
        .l_valid(l_valid),
        .l_wsel(l_wsel),
        .l_wdat(l_wdat),
        .l_ready(l_ready),
        .rf_wen(rf_wen),
        .rf_wsel(rf_wsel),
        .rf_wdat(rf_wdat)
`ifdef RF_WRITE_ARBITER_STATS_EN
        ,
        .stat_drops(stat_drops),
        .stat_forces(stat_forces),
        .stat_writes(stat_writes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic pw, input logic [4:0] ps,
                                input logic [31:0] pd, input logic lv, input logic [4:0] ls,
                                input logic [31:0] ld, input logic eStall, input logic eRdy,
                                input logic eWen, input logic [4:0] eSel,
                                input logic [31:0] eDat, input logic chkDat);
        vec_t v;
        v.id = 0;
        v.rst = r;
        v.pw = pw;
        v.ps = ps;
        v.pd = pd;
        v.lv = lv;
        v.ls = ls;
        v.ld = ld;
        v.eStall = eStall;
        v.eRdy = eRdy;
        v.eWen = eWen;
        v.eSel = eSel;
        v.eDat = eDat;
        v.chkDat = chkDat;
        return v;
    endfunction

    function automatic vec_t idleRow();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    endfunction

    function automatic void checkField(input string what, input int id,
                                       input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL row%0d %s: got %h, expected %h", id, what, act, exp);
        end
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        v.id = rowNum;
        rowNum++;
        rst = v.rst;
        p_wen = v.pw;
        p_wsel = v.ps;
        p_wdat = v.pd;
        l_valid = v.lv;
        l_wsel = v.ls;
        l_wdat = v.ld;
        if (v.rst) begin
            expDrops = 0;
            expForces = 0;
            expWrites = 0;
        end else if (v.eWen) begin
            expWrites++;
        end
        expQ.push_back(v);
    endtask

    function automatic void checkOutput(input vec_t v);
        checkField("p_stall", v.id, 32'(p_stall), 32'(v.eStall));
        checkField("l_ready", v.id, 32'(l_ready), 32'(v.eRdy));
        checkField("rf_wen", v.id, 32'(rf_wen), 32'(v.eWen));
        checkField("rf_wsel", v.id, 32'(rf_wsel), 32'(v.eSel));
        if (v.chkDat)
            checkField("rf_wdat", v.id, rf_wdat, v.eDat);
    endfunction

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            curVec = expQ.pop_front();
            checkOutput(curVec);
        end
    end

    task automatic checkStats(input string tag);
`ifdef RF_WRITE_ARBITER_STATS_EN
        checkField({tag, ".stat_drops"}, rowNum, 32'(stat_drops), 32'(expDrops));
        checkField({tag, ".stat_forces"}, rowNum, 32'(stat_forces), 32'(expForces));
        checkField({tag, ".stat_writes"}, rowNum, 32'(stat_writes), 32'(expWrites));
`else
        if (tag.len() < 0) $display("[TB] %s", tag);
`endif
    endtask

    initial begin
        rst = 1'b1;
        p_wen = 1'b0;
        p_wsel = 5'd0;
        p_wdat = 32'd0;
        l_valid = 1'b0;
        l_wsel = 5'd0;
        l_wdat = 32'd0;

        // Reset gating, P pass-through, L accept/drain, WAW drop, register-0 handling.
        table_q.push_back(mk(1, 1, 3, 32'h33, 1, 2, 32'h22, 0, 0, 0, 0, 32'h0, 1));
        table_q.push_back(mk(0, 1, 5, 32'hAAAA0005, 0, 0, 0, 0, 1, 1, 5, 32'hAAAA0005, 1));
        table_q.push_back(mk(0, 0, 0, 0, 1, 7, 32'h1234, 0, 1, 0, 0, 32'h0, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h1234, 1));
        table_q.push_back(idleRow());
        table_q.push_back(mk(0, 0, 0, 0, 1, 6, 32'h1, 0, 1, 0, 0, 32'h0, 1));
        table_q.push_back(mk(0, 1, 6, 32'h2, 0, 0, 0, 0, 0, 1, 6, 32'h2, 1));
        table_q.push_back(idleRow());
        table_q.push_back(mk(0, 0, 0, 0, 1, 0, 32'hFFFF, 0, 1, 0, 0, 32'h0, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        table_q.push_back(idleRow());
        table_q.push_back(mk(0, 0, 0, 0, 1, 0, 32'hFFFF, 0, 1, 0, 0, 32'h0, 1));
        table_q.push_back(mk(0, 1, 4, 32'h44, 0, 0, 0, 0, 0, 1, 4, 32'h44, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        table_q.push_back(idleRow());
        table_q.push_back(mk(0, 1, 8, 32'h88, 1, 10, 32'hA0, 0, 1, 1, 8, 32'h88, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 32'hA0, 1));
        table_q.push_back(idleRow());
        table_q.push_back(mk(0, 0, 0, 0, 1, 0, 32'h5, 0, 1, 0, 0, 32'h0, 1));
        table_q.push_back(mk(0, 1, 0, 32'h9, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        table_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        table_q.push_back(idleRow());

        for (int i = 0; i < table_q.size(); i++) begin
            applyStimulus(table_q[i]);
            if (i == 6) expDrops++;
        end
        @(posedge clk);
        #1;
        checkStats("after_table");

        // Starvation: buffered reg 9 is forced after LIMIT lost cycles, P's reg 5 replays.
        applyStimulus(mk(0, 0, 0, 0, 1, 9, 32'h99, 0, 1, 0, 0, 32'h0, 1));
        for (int i = 1; i <= LIMIT; i++)
            applyStimulus(mk(0, 1, 5'(i), 32'h10 + 32'(i), 0, 0, 0,
                             0, 0, 1, 5'(i), 32'h10 + 32'(i), 1));
        applyStimulus(mk(0, 1, 5, 32'h55, 0, 0, 0, 1, 0, 1, 9, 32'h99, 1));
        expForces++;
        applyStimulus(mk(0, 1, 5, 32'h55, 0, 0, 0, 0, 1, 1, 5, 32'h55, 1));
        applyStimulus(idleRow());
        @(posedge clk);
        #1;
        checkStats("after_force");

        // Wait count must restart after each drain.
        applyStimulus(mk(0, 0, 0, 0, 1, 11, 32'hB1, 0, 1, 0, 0, 32'h0, 1));
        for (int i = 1; i < LIMIT; i++)
            applyStimulus(mk(0, 1, 5'(i), 32'h20 + 32'(i), 0, 0, 0,
                             0, 0, 1, 5'(i), 32'h20 + 32'(i), 1));
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 32'hB1, 1));
        applyStimulus(mk(0, 0, 0, 0, 1, 12, 32'hC1, 0, 1, 0, 0, 32'h0, 1));
        for (int i = 1; i < LIMIT; i++)
            applyStimulus(mk(0, 1, 5'(i), 32'h30 + 32'(i), 0, 0, 0,
                             0, 0, 1, 5'(i), 32'h30 + 32'(i), 1));
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 32'hC1, 1));
        applyStimulus(idleRow());

        // Reset while an entry waits: entry is lost and never written.
        applyStimulus(mk(0, 0, 0, 0, 1, 13, 32'hDD, 0, 1, 0, 0, 32'h0, 1));
        applyStimulus(mk(1, 1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1));
        applyStimulus(idleRow());
        applyStimulus(idleRow());
        @(posedge clk);
        #1;
        checkStats("after_reset");

        @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
